// File: rtl/gaussian_pixel_pipeline_if.sv
// Pixel stream in, 3x3 window and smoothed pixel out, for the Gaussian front end.
// The master drives the raw stream; the slave (the filter) drives the outputs.
interface gaussian_pixel_pipeline_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0]   pixel_in;
    logic                pixel_in_valid;
    logic [9*DATA_W-1:0] pixel_data_out;
    logic                pixel_data_out_valid;
    logic [DATA_W-1:0]   gaussian_pixel_out;
    logic                gaussian_pixel_out_valid;

    modport master (
        output pixel_in,
        output pixel_in_valid,
        input  pixel_data_out,
        input  pixel_data_out_valid,
        input  gaussian_pixel_out,
        input  gaussian_pixel_out_valid
    );

    modport slave (
        input  pixel_in,
        input  pixel_in_valid,
        output pixel_data_out,
        output pixel_data_out_valid,
        output gaussian_pixel_out,
        output gaussian_pixel_out_valid
    );
endinterface

// File: rtl/gaussian_pixel_pipeline.sv
// Canny front end: two line buffers build a 3x3 window from a raster pixel stream,
// which is smoothed with the [1 2 1; 2 4 2; 1 2 1]/16 kernel, rounded to nearest.
module gaussian_pixel_pipeline #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int DATA_W     = 8
) (
    input  logic                        clk,
    input  logic                        rstN,
    gaussian_pixel_pipeline_if.slave    px
);
    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int WIN_W = 3 * DATA_W;
    localparam int SUM_W = DATA_W + 4;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic               accept;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;

    logic [DATA_W-1:0]  lb1_mem [IMG_WIDTH];
    logic [DATA_W-1:0]  lb2_mem [IMG_WIDTH];
    logic [DATA_W-1:0]  lb1_rd;
    logic [DATA_W-1:0]  lb2_rd;

    logic [WIN_W-1:0]   win0_q, win0_d;
    logic [WIN_W-1:0]   win1_q, win1_d;
    logic [WIN_W-1:0]   win2_q, win2_d;
    logic               win_valid_q, win_valid_d;

    logic [SUM_W-1:0]   sum;
    logic [SUM_W-1:0]   rounded;
    logic [DATA_W-1:0]  gauss_q, gauss_d;
    logic               gauss_valid_q, gauss_valid_d;

    assign accept = px.pixel_in_valid;

    // Position of the pixel being accepted this cycle; frames follow back to back.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // lb1 holds the previous row and lb2 the row before it, both indexed by column.
    assign lb1_rd = lb1_mem[col_q];
    assign lb2_rd = lb2_mem[col_q];

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_mem[col_q] <= px.pixel_in;
            lb2_mem[col_q] <= lb1_rd;
        end
    end

    // Each window row shifts left; the low byte is the newest column.
    always_comb begin
        win0_d      = win0_q;
        win1_d      = win1_q;
        win2_d      = win2_q;
        win_valid_d = 1'b0;
        if (accept) begin
            win0_d      = {win0_q[WIN_W-DATA_W-1:0], lb2_rd};
            win1_d      = {win1_q[WIN_W-DATA_W-1:0], lb1_rd};
            win2_d      = {win2_q[WIN_W-DATA_W-1:0], px.pixel_in};
            win_valid_d = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
        end
    end

    function automatic logic [SUM_W-1:0] row_sum(input logic [WIN_W-1:0] w);
        return SUM_W'(w[WIN_W-1 -: DATA_W])
             + (SUM_W'(w[2*DATA_W-1 -: DATA_W]) << 1)
             + SUM_W'(w[DATA_W-1:0]);
    endfunction

    // Worst case sum is 16*max plus the rounding constant, still inside SUM_W.
    assign sum     = row_sum(win0_q) + (row_sum(win1_q) << 1) + row_sum(win2_q);
    assign rounded = sum + SUM_W'(8);

    always_comb begin
        gauss_d       = gauss_q;
        gauss_valid_d = win_valid_q;
        if (win_valid_q) begin
            gauss_d = DATA_W'(rounded >> 4);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            col_q         <= '0;
            row_q         <= '0;
            win0_q        <= '0;
            win1_q        <= '0;
            win2_q        <= '0;
            win_valid_q   <= 1'b0;
            gauss_q       <= '0;
            gauss_valid_q <= 1'b0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            win0_q        <= win0_d;
            win1_q        <= win1_d;
            win2_q        <= win2_d;
            win_valid_q   <= win_valid_d;
            gauss_q       <= gauss_d;
            gauss_valid_q <= gauss_valid_d;
        end
    end

    assign px.pixel_data_out           = {win0_q, win1_q, win2_q};
    assign px.pixel_data_out_valid     = win_valid_q;
    assign px.gaussian_pixel_out       = gauss_q;
    assign px.gaussian_pixel_out_valid = gauss_valid_q;

endmodule

// File: tb/tb_gaussian_pixel_pipeline.sv
// Scoreboard bench for the Gaussian front end on a reduced 16x10 image: every
// accepted interior pixel queues its expected smoothed value and due cycle.
module tb_gaussian_pixel_pipeline;
    localparam int W = 16;
    localparam int H = 10;
    localparam int N = (W - 2) * (H - 2);

    typedef struct {
        int val;
        int due;
        int r;
        int c;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   cyc;
    int   out_count;
    int   mr;
    int   mc;
    int   obs [H][W];
    logic [7:0] img [H][W];
    exp_t sb [$];

    gaussian_pixel_pipeline_if #(.DATA_W(8)) dut_if ();

    gaussian_pixel_pipeline #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .DATA_W    (8)
    ) dut (
        .clk (clk),
        .rstN(rst_n),
        .px  (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Output monitor: pops the scoreboard on every filtered pulse.
    always begin
        logic acc;
        exp_t e;
        @(posedge clk);
        cyc++;
        acc = dut_if.pixel_in_valid && rst_n;
        #1;
        if (dut_if.pixel_data_out_valid) begin
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL win_valid_after_idle: valid=1 required=0 cycle=%0d", cyc);
            end
        end
        while (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_output: centre (%0d,%0d) due cycle %0d, no pulse observed", e.r, e.c, e.due);
        end
        if (dut_if.gaussian_pixel_out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %0d at cycle %0d, none required", dut_if.gaussian_pixel_out, cyc);
            end else begin
                e = sb.pop_front();
                out_count++;
                obs[e.r][e.c] = int'(dut_if.gaussian_pixel_out);
                if (int'(dut_if.gaussian_pixel_out) !== e.val || cyc != e.due) begin
                    errors++;
                    $display("FAIL gauss_out: centre (%0d,%0d) got %0d at cycle %0d, required %0d at cycle %0d",
                             e.r, e.c, dut_if.gaussian_pixel_out, cyc, e.val, e.due);
                end
            end
        end
    end

    task automatic drive_px(input logic v, input logic [7:0] p);
        exp_t e;
        int   s;
        @(negedge clk);
        dut_if.pixel_in_valid = v;
        dut_if.pixel_in       = p;
        if (v) begin
            img[mr][mc] = p;
            if (mr >= 2 && mc >= 2) begin
                s = img[mr-2][mc-2] + 2*img[mr-2][mc-1] + img[mr-2][mc]
                  + 2*img[mr-1][mc-2] + 4*img[mr-1][mc-1] + 2*img[mr-1][mc]
                  + img[mr][mc-2] + 2*img[mr][mc-1] + img[mr][mc];
                e.val = (s + 8) / 16;
                e.due = cyc + 2;
                e.r   = mr - 1;
                e.c   = mc - 1;
                sb.push_back(e);
            end
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end
        end
    endtask

    task automatic clear_obs();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                obs[r][c] = -1;
        out_count = 0;
    endtask

    task automatic drain();
        repeat (4) drive_px(1'b0, 8'h00);
    endtask

    // kind 0: constant val; kind 1: val at (4,4), zero elsewhere
    task automatic send_frame(input int kind, input logic [7:0] val, input bit gap);
        int g;
        logic [7:0] p;
        g = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (kind == 0) p = val;
                else           p = (r == 4 && c == 4) ? val : 8'd0;
                if (gap && (g % 3 == 2)) begin
                    drive_px(1'b0, 8'hA5);
                    g++;
                end
                drive_px(1'b1, p);
                g++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        dut_if.pixel_in_valid = 1'b0;
        dut_if.pixel_in = 8'd0;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 4;
        if (dut_if.pixel_data_out !== 72'd0) begin errors++; $display("FAIL reset_window: got %h required 0", dut_if.pixel_data_out); end
        if (dut_if.pixel_data_out_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid: got %b required 0", dut_if.pixel_data_out_valid); end
        if (dut_if.gaussian_pixel_out !== 8'd0) begin errors++; $display("FAIL reset_gauss: got %0d required 0", dut_if.gaussian_pixel_out); end
        if (dut_if.gaussian_pixel_out_valid !== 1'b0) begin errors++; $display("FAIL reset_gauss_valid: got %b required 0", dut_if.gaussian_pixel_out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        mr = 0;
        mc = 0;
    endtask

    task automatic test_constant();
        clear_obs();
        send_frame(0, 8'd100, 1'b0);
        drain();
        checks += 4;
        if (out_count != N) begin errors++; $display("FAIL const_count: got %0d required %0d", out_count, N); end
        if (sb.size() != 0) begin errors++; $display("FAIL const_pending: got %0d required 0", sb.size()); end
        if (obs[1][1] != 100) begin errors++; $display("FAIL const_first: got %0d required 100", obs[1][1]); end
        if (obs[H-2][W-2] != 100) begin errors++; $display("FAIL const_last: got %0d required 100", obs[H-2][W-2]); end
    endtask

    task automatic test_impulse();
        int exp_v [9];
        int k;
        clear_obs();
        send_frame(1, 8'd255, 1'b0);
        drain();
        exp_v = '{16, 32, 16, 32, 64, 32, 16, 32, 16};
        k = 0;
        for (int r = 3; r <= 5; r++) begin
            for (int c = 3; c <= 5; c++) begin
                checks++;
                if (obs[r][c] != exp_v[k]) begin
                    errors++;
                    $display("FAIL impulse_(%0d,%0d): got %0d required %0d", r, c, obs[r][c], exp_v[k]);
                end
                k++;
            end
        end
        checks += 3;
        if (obs[2][2] != 0) begin errors++; $display("FAIL impulse_far_a: got %0d required 0", obs[2][2]); end
        if (obs[6][4] != 0) begin errors++; $display("FAIL impulse_far_b: got %0d required 0", obs[6][4]); end
        if (out_count != N) begin errors++; $display("FAIL impulse_count: got %0d required %0d", out_count, N); end
    endtask

    task automatic test_ramp();
        clear_obs();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                drive_px(1'b1, 8'(c));
                if (r == 5 && c == 6) begin
                    @(posedge clk);
                    #1;
                    checks += 3;
                    if (dut_if.pixel_data_out[71:64] !== 8'd4) begin errors++; $display("FAIL ramp_win_oldest: got %0d required 4", dut_if.pixel_data_out[71:64]); end
                    if (dut_if.pixel_data_out[39:32] !== 8'd5) begin errors++; $display("FAIL ramp_win_centre: got %0d required 5", dut_if.pixel_data_out[39:32]); end
                    if (dut_if.pixel_data_out[7:0] !== 8'd6) begin errors++; $display("FAIL ramp_win_newest: got %0d required 6", dut_if.pixel_data_out[7:0]); end
                end
            end
        end
        drain();
        checks += 3;
        if (obs[3][7] != 7) begin errors++; $display("FAIL ramp_c7: got %0d required 7", obs[3][7]); end
        if (obs[6][12] != 12) begin errors++; $display("FAIL ramp_c12: got %0d required 12", obs[6][12]); end
        if (obs[8][1] != 1) begin errors++; $display("FAIL ramp_c1: got %0d required 1", obs[8][1]); end
    endtask

    task automatic test_valid_gaps();
        clear_obs();
        send_frame(0, 8'd100, 1'b1);
        drain();
        checks += 3;
        if (out_count != N) begin errors++; $display("FAIL gaps_count: got %0d required %0d", out_count, N); end
        if (obs[4][7] != 100) begin errors++; $display("FAIL gaps_value: got %0d required 100", obs[4][7]); end
        if (sb.size() != 0) begin errors++; $display("FAIL gaps_pending: got %0d required 0", sb.size()); end
    endtask

    task automatic test_reset_mid_frame();
        clear_obs();
        for (int i = 0; i < 100; i++) drive_px(1'b1, 8'd77);
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        dut_if.pixel_in_valid = 1'b1;
        dut_if.pixel_in = 8'd77;
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (dut_if.pixel_data_out !== 72'd0) begin errors++; $display("FAIL midreset_window: got %h required 0", dut_if.pixel_data_out); end
        if (dut_if.pixel_data_out_valid !== 1'b0) begin errors++; $display("FAIL midreset_win_valid: got %b required 0", dut_if.pixel_data_out_valid); end
        if (dut_if.gaussian_pixel_out !== 8'd0) begin errors++; $display("FAIL midreset_gauss: got %0d required 0", dut_if.gaussian_pixel_out); end
        if (dut_if.gaussian_pixel_out_valid !== 1'b0) begin errors++; $display("FAIL midreset_gauss_valid: got %b required 0", dut_if.gaussian_pixel_out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        dut_if.pixel_in_valid = 1'b0;
        mr = 0;
        mc = 0;
        clear_obs();
        send_frame(0, 8'd50, 1'b0);
        drain();
        checks += 3;
        if (out_count != N) begin errors++; $display("FAIL midreset_count: got %0d required %0d", out_count, N); end
        if (obs[1][1] != 50) begin errors++; $display("FAIL midreset_first: got %0d required 50", obs[1][1]); end
        if (obs[H-2][W-2] != 50) begin errors++; $display("FAIL midreset_last: got %0d required 50", obs[H-2][W-2]); end
    endtask

    task automatic test_back_to_back();
        int first_count;
        clear_obs();
        send_frame(0, 8'd10, 1'b0);
        first_count = out_count;
        send_frame(0, 8'd200, 1'b0);
        drain();
        checks += 3;
        if (out_count != 2 * N) begin errors++; $display("FAIL b2b_count: got %0d required %0d", out_count, 2 * N); end
        if (obs[1][1] != 200) begin errors++; $display("FAIL b2b_second_first: got %0d required 200", obs[1][1]); end
        if (first_count > N) begin errors++; $display("FAIL b2b_first_frame_count: got %0d required at most %0d", first_count, N); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc = 0;
        out_count = 0;
        mr = 0;
        mc = 0;
        test_reset();
        test_constant();
        test_impulse();
        test_ramp();
        test_valid_gaps();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
